// File: rtl/addsub_chunked_if.sv
// addsub_chunked_if
//   Bundles the request and response signals of the chunked adder/subtractor.
//   Request (master -> slave):  start, A, Bx (B ^ Sub), Sub (carry-in, 1 = subtract)
//   Response (slave -> master): busy, done, Result, Carry, Overflow, Zero, Negative
//   The master modport is the requester (ALU front end or testbench); the slave
//   modport is the adder itself.
interface addsub_chunked_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] Bx;
    logic             Sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Result;
    logic             Carry;
    logic             Overflow;
    logic             Zero;
    logic             Negative;

    modport master (
        output start, A, Bx, Sub,
        input  busy, done, Result, Carry, Overflow, Zero, Negative
    );

    modport slave (
        input  start, A, Bx, Sub,
        output busy, done, Result, Carry, Overflow, Zero, Negative
    );
endinterface

// File: rtl/addsub_chunked.sv
// addsub_chunked
//   Multi-cycle adder/subtractor fed by the B-conditioning XOR stage. Computes
//   A + Bx + Sub, CHUNK bits per clock, carrying between chunks in a register so
//   only a CHUNK-bit adder sits on the critical path. Operands are latched on the
//   accepted start; Result and the N/Z/C/V flags change only at the final chunk.
// Ports
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset
//   bus    slave modport of addsub_chunked_if:
//            start/A/Bx/Sub in; busy/done/Result/Carry/Overflow/Zero/Negative out
// Parameters
//   WIDTH  operand width (must match the interface WIDTH)
//   CHUNK  bits added per cycle; WIDTH must be a multiple of CHUNK
module addsub_chunked #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    addsub_chunked_if.slave bus
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    state_t           state;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             carry;
    logic [WIDTH-1:0] acc;

    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] result_r;
    logic             carry_r;
    logic             overflow_r;
    logic             zero_r;
    logic             negative_r;

    int unsigned      lsb;
    logic [CHUNK:0]   chunk_sum;
    logic [WIDTH-1:0] acc_next;
    logic             last_chunk;

    assign lsb        = 32'(idx) * CHUNK;
    assign last_chunk = (idx == IW'(NCHUNK - 1));

    // One chunk of the sum; acc_next is the accumulator with this chunk merged
    // in, so the final edge can publish the whole word without an extra cycle.
    always_comb begin
        chunk_sum = {1'b0, a_reg[lsb +: CHUNK]}
                  + {1'b0, b_reg[lsb +: CHUNK]}
                  + {{CHUNK{1'b0}}, carry};
        acc_next  = acc;
        acc_next[lsb +: CHUNK] = chunk_sum[CHUNK-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            carry      <= 1'b0;
            acc        <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            result_r   <= '0;
            carry_r    <= 1'b0;
            overflow_r <= 1'b0;
            zero_r     <= 1'b0;
            negative_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        a_reg  <= bus.A;
                        b_reg  <= bus.Bx;
                        carry  <= bus.Sub;
                        idx    <= '0;
                        busy_r <= 1'b1;
                        state  <= ADD;
                    end
                end
                ADD: begin
                    acc   <= acc_next;
                    carry <= chunk_sum[CHUNK];
                    if (last_chunk) begin
                        result_r   <= acc_next;
                        carry_r    <= chunk_sum[CHUNK];
                        overflow_r <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                                      (acc_next[WIDTH-1] != a_reg[WIDTH-1]);
                        zero_r     <= (acc_next == '0);
                        negative_r <= acc_next[WIDTH-1];
                        done_r     <= 1'b1;
                        idx        <= '0;
                        state      <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.Result   = result_r;
    assign bus.Carry    = carry_r;
    assign bus.Overflow = overflow_r;
    assign bus.Zero     = zero_r;
    assign bus.Negative = negative_r;

endmodule

// File: tb/tb_addsub_chunked.sv
// tb_addsub_chunked
//   Self-checking bench for addsub_chunked: directed vector table, hand-written
//   busy/reset sequences, and randomized operations checked against a plain
//   arithmetic reference model.
module tb_addsub_chunked;

    localparam int unsigned W = 32;

    logic clk;
    logic rst_n;

    addsub_chunked_if #(.WIDTH(W)) bus ();

    addsub_chunked #(.WIDTH(W), .CHUNK(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    logic [W-1:0] exp_prev = '0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] bx;
        logic         sub;
        logic [W-1:0] res;
        logic [3:0]   cvzn;
    } vec_t;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Reference: full-width arithmetic, flags from their definitions.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] bx, input logic sub,
                         output logic [W-1:0] res, output logic [3:0] cvzn);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, bx} + {{W{1'b0}}, sub};
        res = s[W-1:0];
        cvzn = {s[W], (a[W-1] == bx[W-1]) && (res[W-1] != a[W-1]), res == '0, res[W-1]};
    endtask

    // Issues one operation, scrambles inputs after the start edge, checks busy,
    // latency, that Result holds its old value until done, and the done pulse width.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] bx, input logic sub,
                         input string tag, output logic [W-1:0] res, output logic [3:0] cvzn);
        int lat;
        @(negedge clk);
        bus.A = a; bus.Bx = bx; bus.Sub = sub; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.A = $urandom; bus.Bx = $urandom; bus.Sub = 1'($urandom_range(0, 1));
        chk({tag, " busy"}, W'(bus.busy), W'(1));
        lat = 0;
        while (!bus.done && lat < 20) begin
            chk({tag, " hold"}, bus.Result, exp_prev);
            @(negedge clk);
            lat++;
        end
        chk({tag, " latency"}, W'(lat), W'(4));
        res  = bus.Result;
        cvzn = {bus.Carry, bus.Overflow, bus.Zero, bus.Negative};
        @(negedge clk);
        chk({tag, " done_pulse"}, W'({bus.done, bus.busy}), W'(0));
    endtask

    vec_t vecs[8];

    initial begin
        logic [W-1:0] r, er, b;
        logic [3:0]   f, ef;
        logic         s;

        vecs[0] = '{32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 4'b0000};
        vecs[1] = '{32'h0000_0005, 32'hFFFF_FFFC, 1'b1, 32'h0000_0002, 4'b1000};
        vecs[2] = '{32'h0000_0003, 32'hFFFF_FFFA, 1'b1, 32'hFFFF_FFFE, 4'b0001};
        vecs[3] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 4'b0101};
        vecs[4] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 4'b0000};
        vecs[5] = '{32'h0000_0005, 32'hFFFF_FFFA, 1'b1, 32'h0000_0000, 4'b1010};
        vecs[6] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 4'b1010};
        vecs[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 4'b1110};

        bus.start = 1'b0; bus.A = '0; bus.Bx = '0; bus.Sub = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset busy_done", W'({bus.busy, bus.done}), W'(0));
        chk("reset result", bus.Result, '0);
        chk("reset flags", W'({bus.Carry, bus.Overflow, bus.Zero, bus.Negative}), W'(0));
        rst_n = 1'b1;

        // Directed vectors
        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].a, vecs[i].bx, vecs[i].sub, $sformatf("vec%0d", i), r, f);
            chk($sformatf("vec%0d result", i), r, vecs[i].res);
            chk($sformatf("vec%0d cvzn", i), W'(f), W'(vecs[i].cvzn));
            exp_prev = vecs[i].res;
        end

        // start during ADD and during DONE is ignored, not queued
        @(negedge clk);
        bus.A = 32'h1234_5678; bus.Bx = 32'h1111_1111; bus.Sub = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.A = 32'h0000_0001; bus.Bx = 32'h0000_0001; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int n = 0; n < 10 && !bus.done; n++) @(negedge clk);
        chk("busy_start done seen", W'(bus.done), W'(1));
        chk("busy_start result", bus.Result, 32'h2345_6789);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("start_in_done ignored", W'(bus.busy), W'(0));
        @(negedge clk);
        chk("not queued busy", W'({bus.busy, bus.done}), W'(0));
        chk("not queued result", bus.Result, 32'h2345_6789);
        exp_prev = 32'h2345_6789;

        // Reset in the second ADD cycle
        @(negedge clk);
        bus.A = 32'h7FFF_FFFF; bus.Bx = 32'h1; bus.Sub = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset busy_done", W'({bus.busy, bus.done}), W'(0));
        chk("midreset result", bus.Result, '0);
        chk("midreset flags", W'({bus.Carry, bus.Overflow, bus.Zero, bus.Negative}), W'(0));
        @(negedge clk);
        rst_n = 1'b1;
        exp_prev = '0;
        begin
            logic seen;
            seen = 1'b0;
            for (int n = 0; n < 8; n++) begin
                @(negedge clk);
                if (bus.done || bus.busy) seen = 1'b1;
            end
            chk("midreset no_done", W'(seen), W'(0));
        end
        do_op(32'h0000_00FF, 32'h0000_0001, 1'b0, "post_reset", r, f);
        chk("post_reset result", r, 32'h0000_0100);
        chk("post_reset cvzn", W'(f), W'(4'b0000));
        exp_prev = 32'h0000_0100;

        // Randomized operations vs reference model
        for (int i = 0; i < 40; i++) begin
            s = 1'($urandom_range(0, 1));
            b = $urandom;
            case (i % 4)
                0: r = $urandom;
                1: r = 32'hFFFF_FFFF;
                2: r = {1'b0, 31'($urandom)};
                default: r = $urandom & 32'h00FF_00FF;
            endcase
            model(r, b ^ {W{s}}, s, er, ef);
            do_op(r, b ^ {W{s}}, s, $sformatf("rand%0d", i), r, f);
            chk($sformatf("rand%0d result", i), r, er);
            chk($sformatf("rand%0d cvzn", i), W'(f), W'(ef));
            exp_prev = er;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
